// File: rtl/dtw_query_loader.sv
// dtw_query_loader: pops query samples from the first-word fall-through sink FIFO
// into a local buffer, then holds the buffer stable for the DTW core's random reads.
// Optional feature macro: DTW_QLOAD_MINMAX_EN tracks the query minimum and maximum.
// When the macro is undefined, qry_min and qry_max are tied to their reset constants.
module dtw_query_loader #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned QUERY_LEN_MAX = 256,
    parameter int unsigned ADDR_WIDTH    = 8
) (
    input  logic                  S_AXIS_ACLK,
    input  logic                  S_AXIS_ARESETN,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   query_len,
    output logic                  dtw_fifo_rden,
    input  logic [DATA_WIDTH-1:0] dtw_fifo_dout,
    input  logic                  dtw_fifo_empty,
    input  logic [ADDR_WIDTH-1:0] qry_rd_addr,
    output logic [DATA_WIDTH-1:0] qry_rd_data,
    output logic                  query_ready,
    input  logic                  query_consumed,
    output logic                  busy,
    output logic                  len_err,
    output logic [ADDR_WIDTH:0]   sample_count,
    output logic [DATA_WIDTH-1:0] qry_min,
    output logic [DATA_WIDTH-1:0] qry_max
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LEN_MAX = CNT_WIDTH'(QUERY_LEN_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_WIDTH-1:0]   len_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic                   busy_q;
    logic                   ready_q;
    logic                   len_err_q;
    logic [DATA_WIDTH-1:0]  rd_data_q;
    logic                   start_ok;
    logic                   start_bad;
    logic                   pop;
    logic                   last_pop;
    logic [DATA_WIDTH-1:0]  qbuf [QUERY_LEN_MAX];

    // State register
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, start qualification and the FIFO pop request
    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        pop       = 1'b0;
        last_pop  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (query_len != '0) begin
                        start_ok = 1'b1;
                        state_d  = ST_LOAD;
                    end else begin
                        start_bad = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                pop      = !dtw_fifo_empty && (count_q < len_q) && !abort;
                last_pop = pop && ((count_q + CNT_WIDTH'(1)) == len_q);
                if (last_pop) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (query_consumed) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // abort wins over start, pops and query_consumed
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    assign dtw_fifo_rden = pop;

    // Load length capture (clamped to buffer depth) and stored-sample counter
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            len_q   <= '0;
            count_q <= '0;
        end else if (abort) begin
            count_q <= '0;
        end else if (start_ok) begin
            len_q   <= (query_len > LEN_MAX) ? LEN_MAX : query_len;
            count_q <= '0;
        end else if (pop) begin
            count_q <= count_q + CNT_WIDTH'(1);
        end
    end

    // Registered status outputs
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            busy_q    <= (state_d == ST_LOAD);
            ready_q   <= (state_d == ST_READY);
            len_err_q <= start_bad;
        end
    end

    // Query buffer write; only LOAD pops write, so the buffer is frozen in READY
    always_ff @(posedge S_AXIS_ACLK) begin
        if (pop) begin
            qbuf[count_q[ADDR_WIDTH-1:0]] <= dtw_fifo_dout;
        end
    end

    // Registered random read port for the DTW core, active in every state
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= qbuf[qry_rd_addr];
        end
    end

`ifdef DTW_QLOAD_MINMAX_EN
    logic [DATA_WIDTH-1:0] min_q;
    logic [DATA_WIDTH-1:0] max_q;

    // Running unsigned extrema over the samples popped in the current load
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            min_q <= '1;
            max_q <= '0;
        end else if (abort || start_ok) begin
            min_q <= '1;
            max_q <= '0;
        end else if (pop) begin
            if (dtw_fifo_dout < min_q) begin
                min_q <= dtw_fifo_dout;
            end
            if (dtw_fifo_dout > max_q) begin
                max_q <= dtw_fifo_dout;
            end
        end
    end

    assign qry_min = min_q;
    assign qry_max = max_q;
`else
    assign qry_min = '1;
    assign qry_max = '0;
`endif

    assign busy         = busy_q;
    assign query_ready  = ready_q;
    assign len_err      = len_err_q;
    assign sample_count = count_q;
    assign qry_rd_data  = rd_data_q;

endmodule

// File: tb/tb_dtw_query_loader.sv
// Self-checking bench for dtw_query_loader: queue-based FIFO model, directed and random loads.
module tb_dtw_query_loader;

    localparam int unsigned DW   = 8;
    localparam int unsigned QMAX = 256;
    localparam int unsigned AW   = 8;
    localparam int unsigned CW   = AW + 1;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          abort    = 1'b0;
    logic [CW-1:0] query_len = '0;
    logic          rden;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic [AW-1:0] rd_addr  = '0;
    logic [DW-1:0] rd_data;
    logic          query_ready;
    logic          consumed = 1'b0;
    logic          busy;
    logic          len_err;
    logic [CW-1:0] sample_count;
    logic [DW-1:0] qmin;
    logic [DW-1:0] qmax;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] src[$];
    bit            stall   = 1'b0;
    int            pop_cnt = 0;
    int            bad_pop = 0;
    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc;

    dtw_query_loader #(
        .DATA_WIDTH   (DW),
        .QUERY_LEN_MAX(QMAX),
        .ADDR_WIDTH   (AW)
    ) dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESETN(rst_n),
        .start         (start),
        .abort         (abort),
        .query_len     (query_len),
        .dtw_fifo_rden (rden),
        .dtw_fifo_dout (fifo_dout),
        .dtw_fifo_empty(fifo_empty),
        .qry_rd_addr   (rd_addr),
        .qry_rd_data   (rd_data),
        .query_ready   (query_ready),
        .query_consumed(consumed),
        .busy          (busy),
        .len_err       (len_err),
        .sample_count  (sample_count),
        .qry_min       (qmin),
        .qry_max       (qmax)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: present FIFO head, sample rden before the edge, pop the model after it
    task automatic tick();
        logic took;
        fifo_empty = stall || (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #1;
        took = rden;
        if (took && fifo_empty) bad_pop++;
        @(posedge clk);
        #1;
        if (took) begin
            pop_cnt++;
            if (!fifo_empty) fifo_q.delete(0);
        end
        start    = 1'b0;
        abort    = 1'b0;
        consumed = 1'b0;
    endtask

    task automatic fill_src(input int n);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back(DW'($urandom));
    endtask

    // mode 0: FIFO always ready, 1: empty every other cycle, 2: random starvation
    task automatic wait_ready(input int mode, output int cycles);
        cycles = 0;
        while (query_ready !== 1'b1 && cycles < 4000) begin
            if (mode == 1)      stall = (cycles % 2 == 0);
            else if (mode == 2) stall = ($urandom_range(0, 1) == 1);
            else                stall = 1'b0;
            tick();
            cycles++;
        end
        stall = 1'b0;
    endtask

    // Check a finished query against the first min(len, QMAX) samples offered
    task automatic check_query(input string tag, input int len);
        int            n;
        logic [DW-1:0] emin;
        logic [DW-1:0] emax;
        n = (len > int'(QMAX)) ? int'(QMAX) : len;
        chk({tag, "_ready"},   32'(query_ready), 32'd1);
        chk({tag, "_busy"},    32'(busy), 32'd0);
        chk({tag, "_pops"},    32'(pop_cnt), 32'(n));
        chk({tag, "_emptypop"}, 32'(bad_pop), 32'd0);
        chk({tag, "_count"},   32'(sample_count), 32'(n));
        emin = '1;
        emax = '0;
`ifdef DTW_QLOAD_MINMAX_EN
        for (int i = 0; i < n; i++) begin
            if (src[i] < emin) emin = src[i];
            if (src[i] > emax) emax = src[i];
        end
`endif
        chk({tag, "_min"}, 32'(qmin), 32'(emin));
        chk({tag, "_max"}, 32'(qmax), 32'(emax));
        for (int a = 0; a < n; a++) begin
            rd_addr = AW'(a);
            tick();
            chk({tag, "_rd"}, 32'(rd_data), 32'(src[a]));
        end
        chk({tag, "_nopop_ready"}, 32'(pop_cnt), 32'(n));
        chk({tag, "_ready_hold"},  32'(query_ready), 32'd1);
    endtask

    task automatic begin_load(input int len);
        fifo_q  = src;
        pop_cnt = 0;
        bad_pop = 0;
        query_len = CW'(len);
        start = 1'b1;
        tick();
    endtask

    task automatic release_query(input string tag);
        consumed = 1'b1;
        tick();
        chk({tag, "_rel_ready"}, 32'(query_ready), 32'd0);
        chk({tag, "_rel_busy"},  32'(busy), 32'd0);
        fifo_q.delete();
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_rden",  32'(rden), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ready", 32'(query_ready), 32'd0);
        chk("rst_lenerr", 32'(len_err), 32'd0);
        chk("rst_count", 32'(sample_count), 32'd0);
        chk("rst_rddata", 32'(rd_data), 32'd0);
        chk("rst_min",   32'(qmin), 32'hff);
        chk("rst_max",   32'(qmax), 32'h00);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Normal back-to-back load of four known samples
        src.delete();
        src.push_back(8'h10); src.push_back(8'h20); src.push_back(8'h30); src.push_back(8'h40);
        begin_load(4);
        chk("norm_busy_start", 32'(busy), 32'd1);
        wait_ready(0, cyc);
        chk("norm_latency", 32'(cyc), 32'd4);
        check_query("norm", 4);
        release_query("norm");

        // Starved FIFO: empty on alternate cycles
        fill_src(3);
        begin_load(3);
        wait_ready(1, cyc);
        chk("starve_cycles", 32'(cyc), 32'd6);
        check_query("starve", 3);
        release_query("starve");

        // Zero length start is rejected with a one-cycle len_err
        query_len = '0;
        start = 1'b1;
        tick();
        chk("len0_err",  32'(len_err), 32'd1);
        chk("len0_busy", 32'(busy), 32'd0);
        tick();
        chk("len0_err_clear", 32'(len_err), 32'd0);
        chk("len0_busy_idle", 32'(busy), 32'd0);

        // Oversize length clamps to the buffer depth
        fill_src(300);
        begin_load(300);
        wait_ready(0, cyc);
        check_query("clamp", 300);
        release_query("clamp");

        // Start during LOAD and READY is ignored
        fill_src(5);
        begin_load(5);
        tick();
        tick();
        chk("hs_two_pops", 32'(sample_count), 32'd2);
        stall = 1'b1;
        start = 1'b1;
        query_len = CW'(1);
        tick();
        stall = 1'b0;
        chk("hs_start_in_load_count", 32'(sample_count), 32'd2);
        chk("hs_start_in_load_busy",  32'(busy), 32'd1);
        wait_ready(0, cyc);
        start = 1'b1;
        query_len = CW'(3);
        tick();
        chk("hs_start_in_ready_count", 32'(sample_count), 32'd5);
        chk("hs_start_in_ready_ready", 32'(query_ready), 32'd1);
        check_query("hs", 5);
        release_query("hs");
        fill_src(2);
        begin_load(2);
        wait_ready(0, cyc);
        check_query("hs_second", 2);
        release_query("hs_second");

        // Abort coincident with start after three pops
        fill_src(8);
        begin_load(8);
        tick(); tick(); tick();
        chk("abort_pre_count", 32'(sample_count), 32'd3);
        abort = 1'b1;
        start = 1'b1;
        tick();
        chk("abort_pops",  32'(pop_cnt), 32'd3);
        chk("abort_busy",  32'(busy), 32'd0);
        chk("abort_ready", 32'(query_ready), 32'd0);
        chk("abort_count", 32'(sample_count), 32'd0);
        abort = 1'b1;
        start = 1'b1;
        query_len = CW'(4);
        tick();
        tick(); tick();
        chk("abort_idle_busy", 32'(busy), 32'd0);
        chk("abort_no_rden",   32'(pop_cnt), 32'd3);
        fifo_q.delete();

        // Asynchronous reset in the middle of a load
        fill_src(5);
        begin_load(5);
        tick(); tick();
        fifo_empty = 1'b0;
        fifo_dout  = fifo_q[0];
        #2;
        chk("arst_pre_rden", 32'(rden), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_rden",   32'(rden), 32'd0);
        chk("arst_busy",   32'(busy), 32'd0);
        chk("arst_ready",  32'(query_ready), 32'd0);
        chk("arst_lenerr", 32'(len_err), 32'd0);
        chk("arst_count",  32'(sample_count), 32'd0);
        chk("arst_rddata", 32'(rd_data), 32'd0);
        chk("arst_min",    32'(qmin), 32'hff);
        chk("arst_max",    32'(qmax), 32'h00);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        fifo_q.delete();

        // Random lengths, data and starvation
        for (int t = 0; t < 6; t++) begin
            int len;
            len = int'($urandom_range(1, 40));
            fill_src(len);
            begin_load(len);
            wait_ready(2, cyc);
            check_query("rand", len);
            release_query("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
